// File: rtl/trap_sequencer_if.sv
// ----------------------------------------------------------------------------
// trap_sequencer_if
// Bundles the pipeline, interrupt, return/vector and trap-output signals of
// the trap sequencer. CLK and RST stay as plain ports on the block itself.
//
//   Pipeline side -> sequencer : MEM_WAIT, EXC_EN, EXC_CODE, EXC_PC
//   Interrupts    -> sequencer : INT_EXT, INT_TIMER, INT_ALLOW, INT_PC
//   Return/vector -> sequencer : MRET, MEPC, TRAP_VEC_MODE, TRAP_VEC_BASE
//   Sequencer -> CSR/pipeline  : TRAP_EN, TRAP_CODE, TRAP_PC, FLUSH,
//                                JMP_DO, JMP_PC, BUSY
//
// modport master : the core side that raises requests and consumes results
// modport slave  : the trap sequencer
// ----------------------------------------------------------------------------
interface trap_sequencer_if;
    logic        MEM_WAIT;
    logic        EXC_EN;
    logic [3:0]  EXC_CODE;
    logic [31:0] EXC_PC;

    logic        INT_EXT;
    logic        INT_TIMER;
    logic        INT_ALLOW;
    logic [31:0] INT_PC;

    logic        MRET;
    logic [31:0] MEPC;
    logic [1:0]  TRAP_VEC_MODE;
    logic [31:0] TRAP_VEC_BASE;

    logic        TRAP_EN;
    logic [31:0] TRAP_CODE;
    logic [31:0] TRAP_PC;
    logic        FLUSH;
    logic        JMP_DO;
    logic [31:0] JMP_PC;
    logic        BUSY;

    modport master (
        output MEM_WAIT, EXC_EN, EXC_CODE, EXC_PC,
        output INT_EXT, INT_TIMER, INT_ALLOW, INT_PC,
        output MRET, MEPC, TRAP_VEC_MODE, TRAP_VEC_BASE,
        input  TRAP_EN, TRAP_CODE, TRAP_PC, FLUSH, JMP_DO, JMP_PC, BUSY
    );

    modport slave (
        input  MEM_WAIT, EXC_EN, EXC_CODE, EXC_PC,
        input  INT_EXT, INT_TIMER, INT_ALLOW, INT_PC,
        input  MRET, MEPC, TRAP_VEC_MODE, TRAP_VEC_BASE,
        output TRAP_EN, TRAP_CODE, TRAP_PC, FLUSH, JMP_DO, JMP_PC, BUSY
    );
endinterface

// File: rtl/trap_sequencer.sv
// ----------------------------------------------------------------------------
// trap_sequencer
// Sequences a machine-mode trap: picks an exception or interrupt in IDLE,
// flushes the pipeline while memory drains, strobes the CSR trap write
// (mcause/mepc), then redirects the PC to the mtvec vector. An mret seen in
// IDLE produces a one-cycle redirect to MEPC without leaving IDLE.
//
// Ports
//   CLK  : system clock
//   RST  : synchronous active-high reset
//   bus  : trap_sequencer_if.slave (requests in, trap/redirect results out)
//
// All outputs come straight from flops. Timeline for a request sampled in
// cycle N with MEM_WAIT low: FLUSH from N+1, TRAP_EN at N+2, JMP_DO at N+3,
// back in IDLE at N+4.
// ----------------------------------------------------------------------------
module trap_sequencer (
    input  logic            CLK,
    input  logic            RST,
    trap_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        COMMIT   = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    localparam logic [31:0] CAUSE_EXT_INT   = 32'h8000_000B;
    localparam logic [31:0] CAUSE_TIMER_INT = 32'h8000_0007;

    state_t      state, state_nxt;
    logic [31:0] cause_q, cause_nxt;
    logic [31:0] pc_q, pc_nxt;

    logic        trap_en_q, trap_en_nxt;
    logic        flush_q, flush_nxt;
    logic        jmp_do_q, jmp_do_nxt;
    logic        busy_q, busy_nxt;
    logic [31:0] trap_code_q, trap_code_nxt;
    logic [31:0] trap_pc_q, trap_pc_nxt;
    logic [31:0] jmp_pc_q, jmp_pc_nxt;

    // Vectored mode only applies to interrupts; the cause number (bit 31
    // stripped) selects a 4-byte slot. Sum wraps modulo 2^32.
    function automatic logic [31:0] calc_vector(
        input logic [1:0]  mode,
        input logic [31:0] base,
        input logic [31:0] cause
    );
        if (mode == 2'b01 && cause[31]) begin
            return base + {cause[29:0], 2'b00};
        end
        return base;
    endfunction

    always_comb begin
        state_nxt     = state;
        cause_nxt     = cause_q;
        pc_nxt        = pc_q;
        trap_en_nxt   = 1'b0;
        flush_nxt     = 1'b0;
        jmp_do_nxt    = 1'b0;
        trap_code_nxt = trap_code_q;
        trap_pc_nxt   = trap_pc_q;
        jmp_pc_nxt    = jmp_pc_q;

        case (state)
            IDLE: begin
                // Exception beats external beats timer; any trap beats mret.
                if (bus.EXC_EN) begin
                    cause_nxt = {28'b0, bus.EXC_CODE};
                    pc_nxt    = bus.EXC_PC;
                    state_nxt = DRAIN;
                    flush_nxt = 1'b1;
                end else if (bus.INT_ALLOW && bus.INT_EXT) begin
                    cause_nxt = CAUSE_EXT_INT;
                    pc_nxt    = bus.INT_PC;
                    state_nxt = DRAIN;
                    flush_nxt = 1'b1;
                end else if (bus.INT_ALLOW && bus.INT_TIMER) begin
                    cause_nxt = CAUSE_TIMER_INT;
                    pc_nxt    = bus.INT_PC;
                    state_nxt = DRAIN;
                    flush_nxt = 1'b1;
                end else if (bus.MRET) begin
                    jmp_do_nxt = 1'b1;
                    jmp_pc_nxt = bus.MEPC;
                    flush_nxt  = 1'b1;
                end
            end

            DRAIN: begin
                flush_nxt = 1'b1;
                if (!bus.MEM_WAIT) begin
                    state_nxt     = COMMIT;
                    trap_en_nxt   = 1'b1;
                    trap_code_nxt = cause_q;
                    trap_pc_nxt   = pc_q;
                end
            end

            COMMIT: begin
                // Vector is taken from the mtvec inputs seen during COMMIT.
                flush_nxt  = 1'b1;
                jmp_do_nxt = 1'b1;
                jmp_pc_nxt = calc_vector(bus.TRAP_VEC_MODE, bus.TRAP_VEC_BASE, cause_q);
                state_nxt  = REDIRECT;
            end

            REDIRECT: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // ---- state / output register boundary ----
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            cause_q     <= 32'b0;
            pc_q        <= 32'b0;
            trap_en_q   <= 1'b0;
            flush_q     <= 1'b0;
            jmp_do_q    <= 1'b0;
            busy_q      <= 1'b0;
            trap_code_q <= 32'b0;
            trap_pc_q   <= 32'b0;
            jmp_pc_q    <= 32'b0;
        end else begin
            state       <= state_nxt;
            cause_q     <= cause_nxt;
            pc_q        <= pc_nxt;
            trap_en_q   <= trap_en_nxt;
            flush_q     <= flush_nxt;
            jmp_do_q    <= jmp_do_nxt;
            busy_q      <= busy_nxt;
            trap_code_q <= trap_code_nxt;
            trap_pc_q   <= trap_pc_nxt;
            jmp_pc_q    <= jmp_pc_nxt;
        end
    end

    assign bus.TRAP_EN   = trap_en_q;
    assign bus.TRAP_CODE = trap_code_q;
    assign bus.TRAP_PC   = trap_pc_q;
    assign bus.FLUSH     = flush_q;
    assign bus.JMP_DO    = jmp_do_q;
    assign bus.JMP_PC    = jmp_pc_q;
    assign bus.BUSY      = busy_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// ----------------------------------------------------------------------------
// tb_trap_sequencer
// Directed table of single-request cases, hand-written multi-cycle corner
// sequences (memory stall, reset mid-trap), then randomized traffic checked
// against a timeline-based reference model.
// ----------------------------------------------------------------------------
module tb_trap_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    trap_sequencer_if bus ();

    trap_sequencer dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: tracks one in-flight trap as a timeline. commit_t
    // is the cycle in which the CSR write is visible; it becomes known on
    // the first sampled cycle after the request with MEM_WAIT low.
    // ------------------------------------------------------------------
    longint      t_cyc    = 0;
    bit          pend     = 1'b0;
    longint      commit_t = -1;
    logic [31:0] m_cause  = 32'b0;
    logic [31:0] m_pc     = 32'b0;
    logic        e_trap_en = 1'b0, e_flush = 1'b0, e_jmp_do = 1'b0, e_busy = 1'b0;
    logic [31:0] e_code = 32'b0, e_tpc = 32'b0, e_jpc = 32'b0;

    function automatic logic [31:0] ref_vector(input logic [1:0] mode, input logic [31:0] base,
                                               input logic [31:0] cause);
        if (mode == 2'd1 && cause >= 32'h8000_0000)
            return base + (cause & 32'h3FFF_FFFF) * 32'd4;
        return base;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            pend = 1'b0; commit_t = -1; m_cause = 32'b0; m_pc = 32'b0;
            e_trap_en = 1'b0; e_flush = 1'b0; e_jmp_do = 1'b0; e_busy = 1'b0;
            e_code = 32'b0; e_tpc = 32'b0; e_jpc = 32'b0;
        end else begin
            e_trap_en = 1'b0; e_jmp_do = 1'b0; e_flush = 1'b0;
            if (pend) begin
                if (commit_t < 0 && !bus.MEM_WAIT) commit_t = t_cyc + 1;
                if (commit_t >= 0 && t_cyc + 1 == commit_t) begin
                    e_trap_en = 1'b1; e_code = m_cause; e_tpc = m_pc;
                end
                if (commit_t >= 0 && t_cyc == commit_t) begin
                    e_jmp_do = 1'b1;
                    e_jpc = ref_vector(bus.TRAP_VEC_MODE, bus.TRAP_VEC_BASE, m_cause);
                end
                e_flush = (commit_t < 0) || (t_cyc <= commit_t);
                if (commit_t >= 0 && t_cyc == commit_t + 1) pend = 1'b0;
            end else begin
                if (bus.EXC_EN) begin
                    pend = 1'b1; m_cause = {28'b0, bus.EXC_CODE}; m_pc = bus.EXC_PC;
                end else if (bus.INT_ALLOW && bus.INT_EXT) begin
                    pend = 1'b1; m_cause = 32'h8000_000B; m_pc = bus.INT_PC;
                end else if (bus.INT_ALLOW && bus.INT_TIMER) begin
                    pend = 1'b1; m_cause = 32'h8000_0007; m_pc = bus.INT_PC;
                end
                if (pend) begin
                    commit_t = -1;
                    e_flush  = 1'b1;
                end else if (bus.MRET) begin
                    e_jmp_do = 1'b1; e_jpc = bus.MEPC; e_flush = 1'b1;
                end
            end
            e_busy = pend;
        end
        t_cyc++;
    end

    // ------------------------------------------------------------------
    // Directed table
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        exc_en;
        logic [3:0]  exc_code;
        logic [31:0] exc_pc;
        logic        int_ext;
        logic        int_timer;
        logic        int_allow;
        logic [31:0] int_pc;
        logic        mret;
        logic [31:0] mepc;
        logic [1:0]  mode;
        logic [31:0] base;
        logic        x_trap;
        logic [31:0] x_code;
        logic [31:0] x_pc;
        logic        x_mret;
        logic [31:0] x_jpc;
    } vec_t;

    vec_t tbl [11];

    task automatic clear_req();
        bus.EXC_EN = 1'b0; bus.INT_EXT = 1'b0; bus.INT_TIMER = 1'b0; bus.MRET = 1'b0;
    endtask

    task automatic idle_inputs();
        clear_req();
        bus.MEM_WAIT = 1'b0; bus.EXC_CODE = 4'd0; bus.EXC_PC = 32'b0;
        bus.INT_ALLOW = 1'b0; bus.INT_PC = 32'b0; bus.MEPC = 32'b0;
        bus.TRAP_VEC_MODE = 2'd0; bus.TRAP_VEC_BASE = 32'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        bus.EXC_EN = v.exc_en; bus.EXC_CODE = v.exc_code; bus.EXC_PC = v.exc_pc;
        bus.INT_EXT = v.int_ext; bus.INT_TIMER = v.int_timer; bus.INT_ALLOW = v.int_allow;
        bus.INT_PC = v.int_pc; bus.MRET = v.mret; bus.MEPC = v.mepc;
        bus.TRAP_VEC_MODE = v.mode; bus.TRAP_VEC_BASE = v.base; bus.MEM_WAIT = 1'b0;
        @(negedge clk);
        clear_req();
        chk({tag, "_flush1"}, 128'(bus.FLUSH), 128'(v.x_trap | v.x_mret));
        chk({tag, "_busy1"},  128'(bus.BUSY),  128'(v.x_trap));
        chk({tag, "_jmp1"},   128'(bus.JMP_DO), 128'(v.x_mret));
        if (v.x_mret) chk({tag, "_mepc"}, 128'(bus.JMP_PC), 128'(v.x_jpc));
        if (v.x_trap) begin
            @(negedge clk);
            chk({tag, "_trapen"}, 128'({bus.TRAP_EN, bus.FLUSH, bus.JMP_DO}), 128'(3'b110));
            chk({tag, "_code"},   128'(bus.TRAP_CODE), 128'(v.x_code));
            chk({tag, "_tpc"},    128'(bus.TRAP_PC),   128'(v.x_pc));
            @(negedge clk);
            chk({tag, "_redir"},  128'({bus.TRAP_EN, bus.FLUSH, bus.JMP_DO, bus.BUSY}), 128'(4'b0111));
            chk({tag, "_vec"},    128'(bus.JMP_PC), 128'(v.x_jpc));
            @(negedge clk);
            chk({tag, "_idle"},   128'({bus.TRAP_EN, bus.FLUSH, bus.JMP_DO, bus.BUSY}), 128'(4'b0000));
            chk({tag, "_hold"},   128'({bus.TRAP_CODE, bus.JMP_PC}), 128'({v.x_code, v.x_jpc}));
        end else begin
            @(negedge clk);
            chk({tag, "_quiet"},  128'({bus.TRAP_EN, bus.FLUSH, bus.JMP_DO, bus.BUSY}), 128'(4'b0000));
        end
    endtask

    initial begin
        logic seen_bad;
        tbl[0]  = '{1'b1, 4'd2,  32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 2'd0, 32'h8000,
                    1'b1, 32'h2, 32'h100, 1'b0, 32'h8000};
        tbl[1]  = '{1'b0, 4'd0,  32'h0,   1'b0, 1'b1, 1'b1, 32'h204, 1'b0, 32'h0, 2'd1, 32'h8000,
                    1'b1, 32'h8000_0007, 32'h204, 1'b0, 32'h801C};
        tbl[2]  = '{1'b1, 4'd5,  32'h40,  1'b1, 1'b0, 1'b1, 32'h99,  1'b1, 32'h500, 2'd1, 32'h1000,
                    1'b1, 32'h5, 32'h40, 1'b0, 32'h1000};
        tbl[3]  = '{1'b0, 4'd0,  32'h0,   1'b1, 1'b0, 1'b1, 32'h208, 1'b0, 32'h0, 2'd1, 32'h2000,
                    1'b1, 32'h8000_000B, 32'h208, 1'b0, 32'h202C};
        tbl[4]  = '{1'b0, 4'd0,  32'h0,   1'b1, 1'b1, 1'b1, 32'h20C, 1'b0, 32'h0, 2'd2, 32'h3000,
                    1'b1, 32'h8000_000B, 32'h20C, 1'b0, 32'h3000};
        tbl[5]  = '{1'b0, 4'd0,  32'h0,   1'b0, 1'b1, 1'b1, 32'h210, 1'b0, 32'h0, 2'd3, 32'h4000,
                    1'b1, 32'h8000_0007, 32'h210, 1'b0, 32'h4000};
        tbl[6]  = '{1'b0, 4'd0,  32'h0,   1'b1, 1'b1, 1'b0, 32'h214, 1'b0, 32'h0, 2'd1, 32'h5000,
                    1'b0, 32'h0, 32'h0, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 4'd0,  32'h0,   1'b1, 1'b0, 1'b0, 32'h218, 1'b1, 32'h300, 2'd0, 32'h6000,
                    1'b0, 32'h0, 32'h0, 1'b1, 32'h300};
        tbl[8]  = '{1'b0, 4'd0,  32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'hDEAD_BEE0, 2'd1, 32'h7000,
                    1'b0, 32'h0, 32'h0, 1'b1, 32'hDEAD_BEE0};
        tbl[9]  = '{1'b0, 4'd0,  32'h0,   1'b0, 1'b1, 1'b1, 32'h21C, 1'b0, 32'h0, 2'd1, 32'hFFFF_FFF0,
                    1'b1, 32'h8000_0007, 32'h21C, 1'b0, 32'h0000_000C};
        tbl[10] = '{1'b1, 4'hF,  32'h120, 1'b0, 1'b1, 1'b1, 32'h99,  1'b0, 32'h0, 2'd1, 32'h9000,
                    1'b1, 32'hF, 32'h120, 1'b0, 32'h9000};

        // Reset with a live request on the inputs: outputs must be cleared.
        idle_inputs();
        rst = 1'b1;
        bus.EXC_EN = 1'b1; bus.MRET = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", 128'({bus.TRAP_EN, bus.FLUSH, bus.JMP_DO, bus.BUSY}), 128'(4'b0000));
        chk("rst_data", 128'({bus.TRAP_CODE, bus.TRAP_PC, bus.JMP_PC}), 128'(0));
        idle_inputs();
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run_vec(i, tbl[i]);

        // Exception held off by a 5-cycle memory stall.
        @(negedge clk);
        bus.EXC_EN = 1'b1; bus.EXC_CODE = 4'd3; bus.EXC_PC = 32'h400;
        bus.TRAP_VEC_MODE = 2'd0; bus.TRAP_VEC_BASE = 32'hA000; bus.MEM_WAIT = 1'b1;
        seen_bad = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            clear_req();
            if (!bus.FLUSH || bus.TRAP_EN || !bus.BUSY) seen_bad = 1'b1;
            if (i == 6) bus.MEM_WAIT = 1'b0;
        end
        chk("stall_flush_held", 128'(seen_bad), 128'(0));
        @(negedge clk);
        chk("stall_trapen", 128'({bus.TRAP_EN, bus.FLUSH}), 128'(2'b11));
        chk("stall_code", 128'({bus.TRAP_CODE, bus.TRAP_PC}), 128'({32'h3, 32'h400}));
        @(negedge clk);
        chk("stall_jmp", 128'({bus.JMP_DO, bus.JMP_PC}), 128'({1'b1, 32'hA000}));
        @(negedge clk);
        chk("stall_idle", 128'(bus.BUSY), 128'(0));

        // Reset while in DRAIN aborts the trap for good.
        bus.EXC_EN = 1'b1; bus.EXC_CODE = 4'd6; bus.EXC_PC = 32'h500; bus.MEM_WAIT = 1'b1;
        @(negedge clk);
        clear_req();
        chk("abort_in_drain", 128'({bus.BUSY, bus.FLUSH}), 128'(2'b11));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.MEM_WAIT = 1'b0;
        chk("abort_ctrl", 128'({bus.TRAP_EN, bus.FLUSH, bus.JMP_DO, bus.BUSY}), 128'(4'b0000));
        chk("abort_data", 128'({bus.TRAP_CODE, bus.TRAP_PC, bus.JMP_PC}), 128'(0));
        seen_bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.TRAP_EN || bus.JMP_DO || bus.BUSY) seen_bad = 1'b1;
        end
        chk("abort_no_trap", 128'(seen_bad), 128'(0));

        // Randomized traffic against the reference model, with rare resets.
        rst = 1'b1;
        idle_inputs();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            chk($sformatf("rand_c%0d", c),
                128'({bus.TRAP_EN, bus.FLUSH, bus.JMP_DO, bus.BUSY,
                      bus.TRAP_CODE, bus.TRAP_PC, bus.JMP_PC}),
                128'({e_trap_en, e_flush, e_jmp_do, e_busy, e_code, e_tpc, e_jpc}));
            rst               = ($urandom_range(0, 63) == 0);
            bus.EXC_EN        = ($urandom_range(0, 7) == 0);
            bus.EXC_CODE      = 4'($urandom);
            bus.EXC_PC        = $urandom;
            bus.INT_EXT       = ($urandom_range(0, 5) == 0);
            bus.INT_TIMER     = ($urandom_range(0, 5) == 0);
            bus.INT_ALLOW     = 1'($urandom);
            bus.INT_PC        = $urandom;
            bus.MRET          = ($urandom_range(0, 5) == 0);
            bus.MEPC          = $urandom;
            bus.MEM_WAIT      = ($urandom_range(0, 2) == 0);
            bus.TRAP_VEC_MODE = 2'($urandom);
            bus.TRAP_VEC_BASE = $urandom;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
